instr_fetch_aligner: RTL

Instruction-side counterpart of the PC register: consumes the current `pc`, fetches word-aligned 32-bit words from instruction memory, and extracts 16-bit (RVC) or 32-bit instructions, including 32-bit instructions that straddle a word boundary. It returns `rvc` and a `pc_advance` strobe to the PC register (its `rvc` and `stall_n` inputs), and presents each instruction to decode with a valid/ready handshake. One memory request is outstanding at most.

---
 rtl/instr_fetch_aligner_pkg.sv | 18 +
 rtl/instr_fetch_aligner.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_aligner_pkg.sv
// Shared core configuration for the fetch path: fetch FSM encoding and
// the compressed-instruction test applied to a 16-bit parcel.
package instr_fetch_aligner_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic is_rvc(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_fetch_aligner.sv
// Fetches aligned 32-bit words for the current pc and extracts 16/32-bit
// instructions, stitching 32-bit instructions that straddle a word boundary.
module instr_fetch_aligner
    import instr_fetch_aligner_pkg::*;
(
    input  logic            clk,
    input  logic            rst_sync,
    input  logic [XLEN-1:0] pc,
    input  logic            jump,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            id_ready,
    output logic            rvc,
    output logic            pc_advance,
    output logic [1:0]      dbg_state
);

    // Handshake: decode takes an instruction in any cycle where instr_valid
    // and id_ready are both high and jump is low; that cycle is pc_advance.

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  buf_word_q, buf_word_d;
    logic [29:0]  buf_tag_q, buf_tag_d;
    logic         buf_valid_q, buf_valid_d;
    logic [15:0]  half_lo_q, half_lo_d;
    logic         span_q, span_d;

    logic         hit;
    logic [15:0]  lo_half;
    logic [15:0]  hi_half;
    logic         pc_unused;

    assign pc_unused = pc[0];
    assign hit       = buf_valid_q && (buf_tag_q == pc[31:2]);
    assign lo_half   = buf_word_q[15:0];
    assign hi_half   = buf_word_q[31:16];

    assign imem_addr  = addr_q;
    assign dbg_state  = state_q;
    assign pc_advance = instr_valid & id_ready & ~jump;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        buf_word_d  = buf_word_q;
        buf_tag_d   = buf_tag_q;
        buf_valid_d = buf_valid_q;
        half_lo_d   = half_lo_q;
        span_d      = span_q;
        imem_req    = 1'b0;
        instr       = 32'h0;
        instr_valid = 1'b0;
        rvc         = 1'b0;

        case (state_q)
            IDLE: begin
                if (span_q) begin
                    // Buffer now holds the following word; its low half completes the instruction.
                    if (buf_valid_q) begin
                        instr       = {buf_word_q[15:0], half_lo_q};
                        instr_valid = 1'b1;
                        if (id_ready) begin
                            span_d = 1'b0;
                        end
                    end
                end else if (hit) begin
                    if (!pc[1]) begin
                        instr_valid = 1'b1;
                        if (is_rvc(lo_half)) begin
                            instr = {16'h0, lo_half};
                            rvc   = 1'b1;
                        end else begin
                            instr = buf_word_q;
                        end
                    end else if (is_rvc(hi_half)) begin
                        instr       = {16'h0, hi_half};
                        rvc         = 1'b1;
                        instr_valid = 1'b1;
                    end else begin
                        half_lo_d = hi_half;
                        span_d    = 1'b1;
                        addr_d    = {pc[31:2] + 30'd1, 2'b00};
                        state_d   = FETCH;
                    end
                end else begin
                    addr_d  = {pc[31:2], 2'b00};
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    buf_word_d  = imem_rdata;
                    buf_tag_d   = addr_q[31:2];
                    buf_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect wins over everything; a response already in flight must still be absorbed.
        if (jump) begin
            buf_valid_d = 1'b0;
            span_d      = 1'b0;
            addr_d      = addr_q;
            case (state_q)
                FETCH:   state_d = imem_gnt ? DRAIN : IDLE;
                WAIT:    state_d = imem_rvalid ? IDLE : DRAIN;
                DRAIN:   state_d = imem_rvalid ? IDLE : DRAIN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            buf_word_q  <= 32'h0;
            buf_tag_q   <= 30'h0;
            buf_valid_q <= 1'b0;
            half_lo_q   <= 16'h0;
            span_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            buf_word_q  <= buf_word_d;
            buf_tag_q   <= buf_tag_d;
            buf_valid_q <= buf_valid_d;
            half_lo_q   <= half_lo_d;
            span_q      <= span_d;
        end
    end

endmodule
